// File: rtl/speck32_dec_core.sv
// Iterative SPECK32/64 decryption core: one inverse round per RUN cycle, round keys read highest index first.
// Define SPECK_DEC_2ROUND_EN to run two inverse rounds per cycle (rk0 then rk1); ROUNDS must then be even.
module speck32_dec_core #(
  parameter int ROUNDS = 22,
  parameter int ALPHA  = 7,
  parameter int BETA   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] ct_x,
  input  logic [15:0] ct_y,
  output logic        key_rd,
  output logic [4:0]  key_idx,
  input  logic [15:0] rk0,
  input  logic [15:0] rk1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] pt_x,
  output logic [15:0] pt_y,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } blk_t;

  localparam int AL = ALPHA % 16;
  localparam int BR = BETA % 16;
  localparam logic [4:0] IDX_TOP = 5'(ROUNDS - 1);

  generate
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
      $error("speck32_dec_core: ROUNDS must be in 1..31");
    end
  endgenerate

`ifdef SPECK_DEC_2ROUND_EN
  localparam logic [4:0] IDX_STEP = 5'd2;
  localparam logic [4:0] IDX_LAST = 5'd1;
  generate
    if ((ROUNDS % 2) != 0) begin : g_odd_rounds
      $error("speck32_dec_core: ROUNDS must be even in two-round mode");
    end
  endgenerate
`else
  localparam logic [4:0] IDX_STEP = 5'd1;
  localparam logic [4:0] IDX_LAST = 5'd0;
  logic rk1_unused;
  assign rk1_unused = ^rk1;
`endif

  function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  // Ripple subtractor a + ~b + 1; the final carry (no-borrow) is dropped so results wrap.
  function automatic logic [15:0] rsub(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] nb, d;
    logic        c;
    nb = ~b;
    c  = 1'b1;
    d  = '0;
    for (int i = 0; i < 16; i++) begin
      d[i] = a[i] ^ nb[i] ^ c;
      c    = (a[i] & nb[i]) | (c & (a[i] ^ nb[i]));
    end
    return d;
  endfunction

  function automatic blk_t inv_round(input blk_t b, input logic [15:0] k);
    blk_t        r;
    logic [15:0] t;
    t   = b.x ^ b.y;
    r.y = rotl(t, (16 - BR) % 16);
    r.x = rotl(rsub(b.x ^ k, r.y), AL);
    return r;
  endfunction

  state_t     state_q, state_d;
  blk_t       blk_q, blk_d, blk_r1, blk_rn;
  blk_t       pt_q, pt_d;
  logic [4:0] key_idx_q, key_idx_d;
  logic       rdy_en_q, rdy_en_d;

  assign blk_r1 = inv_round(blk_q, rk0);
`ifdef SPECK_DEC_2ROUND_EN
  assign blk_rn = inv_round(blk_r1, rk1);
`else
  assign blk_rn = blk_r1;
`endif

  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    pt_d      = pt_q;
    key_idx_d = key_idx_q;
    rdy_en_d  = 1'b1;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          blk_d     = '{x: ct_x, y: ct_y};
          key_idx_d = IDX_TOP;
          state_d   = RUN;
        end
      end
      RUN: begin
        blk_d = blk_rn;
        if (key_idx_q == IDX_LAST) begin
          pt_d      = blk_rn;
          key_idx_d = 5'd0;
          state_d   = DONE;
        end else begin
          key_idx_d = key_idx_q - IDX_STEP;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rdy_en_q keeps in_ready low while reset is held, even though the state is IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      blk_q     <= '0;
      pt_q      <= '0;
      key_idx_q <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      pt_q      <= pt_d;
      key_idx_q <= key_idx_d;
      rdy_en_q  <= rdy_en_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && rdy_en_q;
  assign key_rd    = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign key_idx   = key_idx_q;
  assign pt_x      = pt_q.x;
  assign pt_y      = pt_q.y;

endmodule
